// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: load extraction, writeback
// select, 32 x XLEN register file with write-through read ports and a commit counter.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               LoadMux_in,
    input  logic [1:0]               MemToReg_in,
    input  logic                     RegWrite_in,
    input  logic [XLEN-1:0]          ALUResult_in,
    input  logic [XLEN-1:0]          MemContent_in,
    input  logic [XLEN-1:0]          PCplus4_in,
    input  logic [$clog2(NREGS)-1:0] RdAddress_in,
    input  logic [$clog2(NREGS)-1:0] Rs1Address_in,
    input  logic [$clog2(NREGS)-1:0] Rs2Address_in,
    output logic [XLEN-1:0]          Rs1Data_out,
    output logic [XLEN-1:0]          Rs2Data_out,
    output logic [XLEN-1:0]          WbData_out,
    output logic                     WbWe_out,
    output logic [XLEN-1:0]          WbCount_out
);
    localparam int AW = $clog2(NREGS);

    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] wb_count_q;
    logic [XLEN-1:0] wb_count_d;

    // ALUResult_in[0] does not participate in halfword selection.
    always_comb begin
        load_byte = MemContent_in[8*ALUResult_in[1:0] +: 8];
        load_half = ALUResult_in[1] ? MemContent_in[31:16] : MemContent_in[15:0];
        case (LoadMux_in)
            2'b00:   load_data = MemContent_in;
            2'b01:   load_data = {{(XLEN-16){load_half[15]}}, load_half};
            2'b10:   load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            default: load_data = {{(XLEN-8){1'b0}}, load_byte};
        endcase
    end

    always_comb begin
        case (MemToReg_in)
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = PCplus4_in;
            default: wb_data = ALUResult_in;
        endcase
    end

    assign wb_we      = RegWrite_in && (RdAddress_in != '0) && !rst;
    assign wb_count_d = wb_count_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else if (wb_we) begin
            regs_q[RdAddress_in] <= wb_data;
            wb_count_q           <= wb_count_d;
        end
    end

    // Read ports: x0 is zero, then same-cycle bypass of the value being committed.
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];

    assign rd_addr[0] = Rs1Address_in;
    assign rd_addr[1] = Rs2Address_in;

    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                             (wb_we && (rd_addr[gi] == RdAddress_in)) ? wb_data :
                             regs_q[rd_addr[gi]];
    end

    assign Rs1Data_out = rd_data[0];
    assign Rs2Data_out = rd_data[1];
    assign WbData_out  = wb_data;
    assign WbWe_out    = wb_we;
    assign WbCount_out = wb_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: reference model checked every negedge plus directed literal checks.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  LoadMux_in = '0;
    logic [1:0]  MemToReg_in = '0;
    logic        RegWrite_in = 1'b0;
    logic [31:0] ALUResult_in = '0;
    logic [31:0] MemContent_in = '0;
    logic [31:0] PCplus4_in = '0;
    logic [4:0]  RdAddress_in = '0;
    logic [4:0]  Rs1Address_in = '0;
    logic [4:0]  Rs2Address_in = '0;
    logic [31:0] Rs1Data_out, Rs2Data_out, WbData_out, WbCount_out;
    logic        WbWe_out;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b1;

    wb_regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .LoadMux_in(LoadMux_in), .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
        .ALUResult_in(ALUResult_in), .MemContent_in(MemContent_in), .PCplus4_in(PCplus4_in),
        .RdAddress_in(RdAddress_in), .Rs1Address_in(Rs1Address_in), .Rs2Address_in(Rs2Address_in),
        .Rs1Data_out(Rs1Data_out), .Rs2Data_out(Rs2Data_out), .WbData_out(WbData_out),
        .WbWe_out(WbWe_out), .WbCount_out(WbCount_out)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    function automatic logic [31:0] m_wbdata();
        logic [31:0] shifted;
        int          off;
        off = int'(ALUResult_in[1:0]);
        if (MemToReg_in == 2'd2) return PCplus4_in;
        if (MemToReg_in != 2'd1) return ALUResult_in;
        case (LoadMux_in)
            2'd0: return MemContent_in;
            2'd1: begin
                shifted = MemContent_in >> (16 * (off / 2));
                return 32'($signed(shifted[15:0]));
            end
            2'd2: begin
                shifted = MemContent_in >> (8 * off);
                return 32'($signed(shifted[7:0]));
            end
            default: begin
                shifted = MemContent_in >> (8 * off);
                return shifted & 32'hFF;
            end
        endcase
    endfunction

    function automatic bit m_we();
        return RegWrite_in && RdAddress_in != 0 && !rst;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (m_we() && a == RdAddress_in) return m_wbdata();
        return m_regs[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
            m_count <= '0;
        end else if (m_we()) begin
            m_regs[RdAddress_in] <= m_wbdata();
            m_count <= m_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare process: every negedge, all outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_wbdata", WbData_out, m_wbdata());
            chk("cmp_wbwe", {31'd0, WbWe_out}, {31'd0, m_we()});
            chk("cmp_rs1", Rs1Data_out, m_read(Rs1Address_in));
            chk("cmp_rs2", Rs2Data_out, m_read(Rs2Address_in));
            chk("cmp_count", WbCount_out, m_count);
            $display("t=%0t rst=%0b we=%0b rd=%0d wb=0x%08h rs1[%0d]=0x%08h rs2[%0d]=0x%08h cnt=%0d",
                     $time, rst, WbWe_out, RdAddress_in, WbData_out,
                     Rs1Address_in, Rs1Data_out, Rs2Address_in, Rs2Data_out, WbCount_out);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [1:0] lm, input logic [31:0] alu);
        RegWrite_in  = we;
        RdAddress_in = rd;
        MemToReg_in  = sel;
        LoadMux_in   = lm;
        ALUResult_in = alu;
        #1;
    endtask

    initial begin
        // Reset state, with a write presented that must be blocked
        Rs1Address_in = 5'd5;
        Rs2Address_in = 5'd7;
        set_wb(1'b1, 5'd5, 2'd0, 2'd0, 32'h0000_0055);
        chk("rst_rs1", Rs1Data_out, 32'd0);
        chk("rst_wbwe", {31'd0, WbWe_out}, 32'd0);
        chk("rst_wbdata_follows", WbData_out, 32'h0000_0055);
        next_cycle();
        chk("rst_count", WbCount_out, 32'd0);
        RegWrite_in = 1'b0;
        rst = 1'b0;
        next_cycle();

        // ALU writeback with same-cycle bypass
        Rs1Address_in = 5'd7;
        set_wb(1'b1, 5'd7, 2'd0, 2'd0, 32'h1234_5678);
        chk("alu_bypass", Rs1Data_out, 32'h1234_5678);
        chk("alu_count_pre", WbCount_out, 32'd0);
        next_cycle();
        set_wb(1'b0, 5'd7, 2'd0, 2'd0, 32'h0);
        chk("alu_stored", Rs1Data_out, 32'h1234_5678);
        chk("alu_count_post", WbCount_out, 32'd1);

        // Load extraction
        MemContent_in = 32'h80F1_7F01;
        set_wb(1'b1, 5'd10, 2'd1, 2'd2, 32'h0000_1002);
        chk("lb_off2", WbData_out, 32'hFFFF_FFF1);
        next_cycle();
        set_wb(1'b1, 5'd11, 2'd1, 2'd3, 32'h0000_1003);
        chk("lbu_off3", WbData_out, 32'h0000_0080);
        next_cycle();
        set_wb(1'b1, 5'd12, 2'd1, 2'd1, 32'h0000_1002);
        chk("lh_off2", WbData_out, 32'hFFFF_80F1);
        next_cycle();
        set_wb(1'b1, 5'd13, 2'd1, 2'd1, 32'h0000_1000);
        chk("lh_off0", WbData_out, 32'h0000_7F01);
        next_cycle();
        set_wb(1'b1, 5'd14, 2'd1, 2'd0, 32'h0000_1000);
        chk("lw", WbData_out, 32'h80F1_7F01);
        next_cycle();
        set_wb(1'b1, 5'd15, 2'd1, 2'd2, 32'h0000_1001);
        chk("lb_off1", WbData_out, 32'h0000_007F);
        next_cycle();
        Rs1Address_in = 5'd10;
        Rs2Address_in = 5'd12;
        set_wb(1'b0, 5'd0, 2'd0, 2'd0, 32'h0);
        chk("ld_x10", Rs1Data_out, 32'hFFFF_FFF1);
        chk("ld_x12", Rs2Data_out, 32'hFFFF_80F1);
        chk("ld_count", WbCount_out, 32'd7);

        // x0 protection
        Rs1Address_in = 5'd0;
        set_wb(1'b1, 5'd0, 2'd0, 2'd0, 32'hDEAD_BEEF);
        chk("x0_rs1", Rs1Data_out, 32'd0);
        chk("x0_wbwe", {31'd0, WbWe_out}, 32'd0);
        next_cycle();
        chk("x0_count", WbCount_out, 32'd7);

        // Link and reserved select
        PCplus4_in = 32'd1000;
        set_wb(1'b1, 5'd1, 2'd2, 2'd0, 32'h0000_00AA);
        next_cycle();
        Rs1Address_in = 5'd1;
        set_wb(1'b1, 5'd2, 2'd3, 2'd0, 32'd1);
        chk("link_x1", Rs1Data_out, 32'd1000);
        chk("reserved_sel", WbData_out, 32'd1);
        next_cycle();

        // Dual read and bubble
        set_wb(1'b1, 5'd3, 2'd0, 2'd0, 32'd5);
        next_cycle();
        Rs1Address_in = 5'd3;
        Rs2Address_in = 5'd3;
        set_wb(1'b0, 5'd3, 2'd0, 2'd0, 32'd9);
        chk("dual_rs1", Rs1Data_out, 32'd5);
        chk("dual_rs2", Rs2Data_out, 32'd5);
        next_cycle();
        chk("bubble_count", WbCount_out, 32'd10);

        // Both ports hitting bypass on x5
        Rs1Address_in = 5'd5;
        Rs2Address_in = 5'd5;
        set_wb(1'b1, 5'd5, 2'd0, 2'd0, 32'hCAFE_0005);
        chk("dual_bypass_rs2", Rs2Data_out, 32'hCAFE_0005);
        next_cycle();
        set_wb(1'b0, 5'd0, 2'd0, 2'd0, 32'h0);
        chk("x5_stored", Rs1Data_out, 32'hCAFE_0005);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_x5", Rs1Data_out, 32'd0);
        chk("async_rst_count", WbCount_out, 32'd0);

        // Write held across reset release: not committed on the edge while rst is high
        set_wb(1'b1, 5'd9, 2'd0, 2'd0, 32'h0000_0099);
        Rs1Address_in = 5'd9;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rel_count", WbCount_out, 32'd0);
        chk("rel_bypass", Rs1Data_out, 32'h0000_0099);
        next_cycle();
        set_wb(1'b0, 5'd0, 2'd0, 2'd0, 32'h0);
        chk("rel_commit", Rs1Data_out, 32'h0000_0099);
        chk("rel_count_post", WbCount_out, 32'd1);

        // A few mixed cycles for the compare process
        for (int i = 1; i < 8; i++) begin
            Rs1Address_in = 5'(i);
            Rs2Address_in = 5'(i + 8);
            MemContent_in = 32'h1357_9BDF * i;
            set_wb(1'b1, 5'(i + 8), 2'(i % 3), 2'(i % 4), 32'h0000_0100 + i);
            next_cycle();
        end

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
